// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave):
// a req/gnt request handshake followed by an rvalid load response.
interface memory_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues data-memory loads/stores, extends load data and
// fills the memory/writeback register, stalling execute while an access is pending.
module memory_stage #(
    parameter int XLEN        = 32,
    parameter int LOAD_WIDTH  = 5,
    parameter int STORE_WIDTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   execute_vaild_i,
    input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
    input  logic [STORE_WIDTH-1:0] ED_store_op_i,
    input  logic [XLEN-1:0]        ED_valE_i,
    input  logic [XLEN-1:0]        ED_rs2_data_i,
    input  logic                   ED_need_dstE_i,
    input  logic [4:0]             ED_dstE_i,
    input  logic                   ED_sel_reg_i,
    input  logic [XLEN-1:0]        ED_PC_i,
    input  logic                   ED_commit_i,
    input  logic                   writeback_allow_in_i,
    memory_stage_if.master         dmem,
    output logic                   memory_allow_in_o,
    output logic                   memory_vaild_o,
    output logic [XLEN-1:0]        MD_valE_o,
    output logic [XLEN-1:0]        MD_valM_o,
    output logic                   MD_need_dstE_o,
    output logic [4:0]             MD_dstE_o,
    output logic                   MD_sel_reg_o,
    output logic [XLEN-1:0]        MD_PC_o,
    output logic                   MD_commit_o,
    output logic                   MD_misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t          state;
    logic [XLEN-1:0] valm_buf;

    logic            is_load;
    logic            is_store;
    logic            memop;
    logic            half_access;
    logic            word_access;
    logic            misaligned;
    logic            done;
    logic [1:0]      off;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] valm_next;

    assign off         = ED_valE_i[1:0];
    assign is_load     = |ED_load_op_i;
    assign is_store    = |ED_store_op_i;
    assign memop       = execute_vaild_i & (is_load | is_store);
    assign half_access = ED_load_op_i[1] | ED_load_op_i[4] | ED_store_op_i[1];
    assign word_access = ED_load_op_i[2] | ED_store_op_i[2];
    assign misaligned  = memop & ((half_access & off[0]) | (word_access & (|off)));

    // A request is only ever raised from IDLE, so at most one access is outstanding.
    assign dmem.req  = (state == IDLE) & memop & ~misaligned;
    assign dmem.we   = is_store;
    assign dmem.addr = {ED_valE_i[XLEN-1:2], 2'b00};

    assign done = ~execute_vaild_i | ~memop | misaligned
                | (dmem.req & dmem.gnt & is_store)
                | ((state == WAIT) & dmem.rvalid)
                | (state == HOLD);

    assign memory_allow_in_o = done & writeback_allow_in_i;

    always_comb begin
        dmem.wdata = ED_rs2_data_i;
        dmem.wstrb = 4'b1111;
        if (ED_store_op_i[0]) begin
            dmem.wdata = {4{ED_rs2_data_i[7:0]}};
            dmem.wstrb = 4'b0001 << off;
        end else if (ED_store_op_i[1]) begin
            dmem.wdata = {2{ED_rs2_data_i[15:0]}};
            dmem.wstrb = off[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        load_byte = dmem.rdata[7:0];
        case (off)
            2'd1:    load_byte = dmem.rdata[15:8];
            2'd2:    load_byte = dmem.rdata[23:16];
            2'd3:    load_byte = dmem.rdata[31:24];
            default: load_byte = dmem.rdata[7:0];
        endcase
        load_half = off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        load_ext  = dmem.rdata;
        if (ED_load_op_i[0])
            load_ext = {{(XLEN-8){load_byte[7]}}, load_byte};
        else if (ED_load_op_i[1])
            load_ext = {{(XLEN-16){load_half[15]}}, load_half};
        else if (ED_load_op_i[3])
            load_ext = {{(XLEN-8){1'b0}}, load_byte};
        else if (ED_load_op_i[4])
            load_ext = {{(XLEN-16){1'b0}}, load_half};
    end

    // Once writeback has stalled a finished load, the bus data is gone; use the buffer.
    always_comb begin
        valm_next = '0;
        if (is_load & ~misaligned)
            valm_next = (state == HOLD) ? valm_buf : load_ext;
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state    <= IDLE;
            valm_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem.req && dmem.gnt) begin
                        if (is_load)
                            state <= WAIT;
                        else if (!writeback_allow_in_i)
                            state <= HOLD;
                    end
                end
                WAIT: begin
                    if (dmem.rvalid) begin
                        if (writeback_allow_in_i) begin
                            state <= IDLE;
                        end else begin
                            valm_buf <= load_ext;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (writeback_allow_in_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            memory_vaild_o <= 1'b0;
            MD_valE_o      <= '0;
            MD_valM_o      <= '0;
            MD_need_dstE_o <= 1'b0;
            MD_dstE_o      <= '0;
            MD_sel_reg_o   <= 1'b0;
            MD_PC_o        <= '0;
            MD_commit_o    <= 1'b0;
            MD_misalign_o  <= 1'b0;
        end else if (memory_allow_in_o) begin
            memory_vaild_o <= execute_vaild_i;
            if (execute_vaild_i) begin
                MD_valE_o      <= ED_valE_i;
                MD_valM_o      <= valm_next;
                MD_need_dstE_o <= ED_need_dstE_i & ~misaligned;
                MD_dstE_o      <= ED_dstE_i;
                MD_sel_reg_o   <= ED_sel_reg_i;
                MD_PC_o        <= ED_PC_i;
                MD_commit_o    <= ED_commit_i;
                MD_misalign_o  <= misaligned;
            end else begin
                MD_valE_o      <= '0;
                MD_valM_o      <= '0;
                MD_need_dstE_o <= 1'b0;
                MD_dstE_o      <= '0;
                MD_sel_reg_o   <= 1'b0;
                MD_PC_o        <= '0;
                MD_commit_o    <= 1'b0;
                MD_misalign_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, randomized
// transactions against a size/offset reference model, and reset corner cases.
module tb_memory_stage;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst;
    logic            execute_vaild;
    logic [4:0]      ED_load_op;
    logic [2:0]      ED_store_op;
    logic [31:0]     ED_valE;
    logic [31:0]     ED_rs2_data;
    logic            ED_need_dstE;
    logic [4:0]      ED_dstE;
    logic            ED_sel_reg;
    logic [31:0]     ED_PC;
    logic            ED_commit;
    logic            writeback_allow_in;
    logic            memory_allow_in;
    logic            memory_vaild;
    logic [31:0]     MD_valE;
    logic [31:0]     MD_valM;
    logic            MD_need_dstE;
    logic [4:0]      MD_dstE;
    logic            MD_sel_reg;
    logic [31:0]     MD_PC;
    logic            MD_commit;
    logic            MD_misalign;

    memory_stage_if #(.XLEN(XLEN)) bus ();

    memory_stage #(.XLEN(XLEN)) dut (
        .clk_i               (clk_i),
        .rst                 (rst),
        .execute_vaild_i     (execute_vaild),
        .ED_load_op_i        (ED_load_op),
        .ED_store_op_i       (ED_store_op),
        .ED_valE_i           (ED_valE),
        .ED_rs2_data_i       (ED_rs2_data),
        .ED_need_dstE_i      (ED_need_dstE),
        .ED_dstE_i           (ED_dstE),
        .ED_sel_reg_i        (ED_sel_reg),
        .ED_PC_i             (ED_PC),
        .ED_commit_i         (ED_commit),
        .writeback_allow_in_i(writeback_allow_in),
        .dmem                (bus),
        .memory_allow_in_o   (memory_allow_in),
        .memory_vaild_o      (memory_vaild),
        .MD_valE_o           (MD_valE),
        .MD_valM_o           (MD_valM),
        .MD_need_dstE_o      (MD_need_dstE),
        .MD_dstE_o           (MD_dstE),
        .MD_sel_reg_o        (MD_sel_reg),
        .MD_PC_o             (MD_PC),
        .MD_commit_o         (MD_commit),
        .MD_misalign_o       (MD_misalign)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  ld;
        logic [2:0]  st;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [31:0] valM;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        mis;
        int          gntDelay;
        int          rvDelay;
        int          wbStall;
    } vector_t;

    vector_t     vec [14];
    int          total = 0;
    int          bad = 0;
    logic [31:0] expPrevPc = 32'h0;
    logic [31:0] pcCount = 32'h8000_0000;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: derived from access size and byte offset only.
    task automatic refModel(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [31:0] rdata,
                            output logic [31:0] valM, output logic [31:0] wdata,
                            output logic [3:0] wstrb, output logic mis);
        int     size;
        int     off;
        longint b;
        size = (ld[0] || ld[3] || st[0]) ? 1 : (ld[1] || ld[4] || st[1]) ? 2 : 4;
        off  = int'(addr % 4);
        mis  = ((ld != 0) || (st != 0)) && ((addr % size) != 0);
        valM = 32'h0;
        if (ld[2]) begin
            valM = rdata;
        end else if (ld != 0) begin
            b = longint'((rdata >> (8 * off)) % (1 << (8 * size)));
            if ((ld[0] || ld[1]) && b >= (1 << (8 * size - 1)))
                b = b - (longint'(1) << (8 * size));
            valM = b[31:0];
        end
        wdata = (size == 1) ? (rs2 % 256) * 32'h0101_0101 :
                (size == 2) ? (rs2 % 65536) * 32'h0001_0001 : rs2;
        wstrb = 4'(((1 << size) - 1) << off);
    endtask

    task automatic applyStimulus(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic [31:0] rdata,
                                 input logic [31:0] expValM, input logic [31:0] expWdata,
                                 input logic [3:0] expWstrb, input logic expMis,
                                 input int gntDelay, input int rvDelay, input int wbStall,
                                 input string tag);
        logic       isLoad;
        logic       isStore;
        logic       alignedMem;
        int         gntCycle;
        int         compCycle;
        int         capCycle;
        logic [4:0] dst;
        logic       commit;
        isLoad     = (ld != 0);
        isStore    = (st != 0);
        alignedMem = (isLoad || isStore) && !expMis;
        gntCycle   = gntDelay;
        compCycle  = !alignedMem ? 0 : isStore ? gntCycle : gntCycle + rvDelay;
        capCycle   = compCycle + wbStall;
        dst        = 5'($urandom_range(1, 31));
        commit     = 1'($urandom_range(0, 1));
        pcCount    = pcCount + 4;
        for (int c = 0; c <= capCycle; c++) begin
            @(negedge clk_i);
            execute_vaild      = 1'b1;
            ED_load_op         = ld;
            ED_store_op        = st;
            ED_valE            = addr;
            ED_rs2_data        = rs2;
            ED_need_dstE       = 1'b1;
            ED_dstE            = dst;
            ED_sel_reg         = isLoad;
            ED_PC              = pcCount;
            ED_commit          = commit;
            bus.gnt            = alignedMem && (c == gntCycle);
            bus.rvalid         = isLoad && alignedMem && (c == compCycle);
            bus.rdata          = bus.rvalid ? rdata : $urandom;
            writeback_allow_in = !(c >= compCycle && c < capCycle);
            #1;
            checkOutput({tag, " allow_in"}, 32'(memory_allow_in), 32'(c == capCycle));
            checkOutput({tag, " req"}, 32'(bus.req), 32'(alignedMem && c <= gntCycle));
            if (alignedMem && c == gntCycle) begin
                checkOutput({tag, " addr"}, bus.addr, addr & 32'hFFFF_FFFC);
                checkOutput({tag, " we"}, 32'(bus.we), 32'(isStore));
                if (isStore) begin
                    checkOutput({tag, " wdata"}, bus.wdata, expWdata);
                    checkOutput({tag, " wstrb"}, 32'(bus.wstrb), 32'(expWstrb));
                end
            end
            if (c < capCycle)
                checkOutput({tag, " MD hold"}, MD_PC, expPrevPc);
        end
        @(posedge clk_i);
        #1;
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        checkOutput({tag, " vaild"}, 32'(memory_vaild), 32'h1);
        checkOutput({tag, " valE"}, MD_valE, addr);
        checkOutput({tag, " valM"}, MD_valM, (isLoad && !expMis) ? expValM : 32'h0);
        checkOutput({tag, " need_dstE"}, 32'(MD_need_dstE), 32'(!expMis));
        checkOutput({tag, " dstE"}, 32'(MD_dstE), 32'(dst));
        checkOutput({tag, " sel_reg"}, 32'(MD_sel_reg), 32'(isLoad));
        checkOutput({tag, " PC"}, MD_PC, pcCount);
        checkOutput({tag, " commit"}, 32'(MD_commit), 32'(commit));
        checkOutput({tag, " misalign"}, 32'(MD_misalign), 32'(expMis));
        expPrevPc = pcCount;
    endtask

    initial begin
        logic [4:0]  rLd;
        logic [2:0]  rSt;
        logic [31:0] rAddr;
        logic [31:0] rRs2;
        logic [31:0] rRdata;
        logic [31:0] mValM;
        logic [31:0] mWdata;
        logic [3:0]  mWstrb;
        logic        mMis;
        int          kind;

        //          ld     st     addr          rs2           rdata         valM          wdata         wstrb    mis  g  r  wb
        vec[0]  = '{5'd1,  3'd0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 32'hFFFF_FF80, 32'h0,        4'b0000, 1'b0, 0, 2, 0};
        vec[1]  = '{5'd8,  3'd0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 32'h0000_0080, 32'h0,        4'b0000, 1'b0, 0, 2, 0};
        vec[2]  = '{5'd2,  3'd0, 32'h0000_1002, 32'h0,        32'h80FF_0000, 32'hFFFF_80FF, 32'h0,        4'b0000, 1'b0, 1, 1, 0};
        vec[3]  = '{5'd16, 3'd0, 32'h0000_1000, 32'h0,        32'h1234_F00D, 32'h0000_F00D, 32'h0,        4'b0000, 1'b0, 0, 1, 0};
        vec[4]  = '{5'd2,  3'd0, 32'h0000_1000, 32'h0,        32'h1234_F00D, 32'hFFFF_F00D, 32'h0,        4'b0000, 1'b0, 2, 1, 1};
        vec[5]  = '{5'd4,  3'd0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,        4'b0000, 1'b0, 0, 1, 3};
        vec[6]  = '{5'd1,  3'd0, 32'h0000_1001, 32'h0,        32'h1122_7F44, 32'h0000_007F, 32'h0,        4'b0000, 1'b0, 0, 3, 0};
        vec[7]  = '{5'd0,  3'd2, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        32'h0,        32'hABCD_ABCD, 4'b1100, 1'b0, 0, 1, 0};
        vec[8]  = '{5'd0,  3'd1, 32'h0000_2001, 32'h0000_00AA, 32'h0,        32'h0,        32'hAAAA_AAAA, 4'b0010, 1'b0, 1, 1, 2};
        vec[9]  = '{5'd0,  3'd4, 32'h0000_2008, 32'hCAFE_F00D, 32'h0,        32'h0,        32'hCAFE_F00D, 4'b1111, 1'b0, 0, 1, 0};
        vec[10] = '{5'd4,  3'd0, 32'h0000_1002, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 1'b1, 0, 1, 0};
        vec[11] = '{5'd2,  3'd0, 32'h0000_1001, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 1'b1, 0, 1, 0};
        vec[12] = '{5'd0,  3'd4, 32'h0000_2001, 32'h5555_5555, 32'h0,        32'h0,        32'h0,        4'b0000, 1'b1, 0, 1, 1};
        vec[13] = '{5'd0,  3'd0, 32'h0000_1234, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 1'b0, 0, 1, 1};

        rst                = 1'b0;
        execute_vaild      = 1'b0;
        ED_load_op         = '0;
        ED_store_op        = '0;
        ED_valE            = '0;
        ED_rs2_data        = '0;
        ED_need_dstE       = 1'b0;
        ED_dstE            = '0;
        ED_sel_reg         = 1'b0;
        ED_PC              = '0;
        ED_commit          = 1'b0;
        writeback_allow_in = 1'b1;
        bus.gnt            = 1'b0;
        bus.rvalid         = 1'b0;
        bus.rdata          = '0;

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset vaild", 32'(memory_vaild), 32'h0);
        checkOutput("reset valE", MD_valE, 32'h0);
        checkOutput("reset misalign", 32'(MD_misalign), 32'h0);
        checkOutput("reset req", 32'(bus.req), 32'h0);
        @(negedge clk_i);
        rst = 1'b1;

        // Bubble: an empty execute slot passes straight through as a cleared MD entry.
        @(negedge clk_i);
        execute_vaild = 1'b0;
        #1;
        checkOutput("bubble allow_in", 32'(memory_allow_in), 32'h1);
        @(posedge clk_i);
        #1;
        checkOutput("bubble vaild", 32'(memory_vaild), 32'h0);

        for (int i = 0; i < 14; i++)
            applyStimulus(vec[i].ld, vec[i].st, vec[i].addr, vec[i].rs2, vec[i].rdata,
                          vec[i].valM, vec[i].wdata, vec[i].wstrb, vec[i].mis,
                          vec[i].gntDelay, vec[i].rvDelay, vec[i].wbStall, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            kind   = int'($urandom_range(0, 8));
            rLd    = (kind < 5) ? 5'(1 << kind) : 5'd0;
            rSt    = (kind >= 5 && kind < 8) ? 3'(1 << (kind - 5)) : 3'd0;
            rAddr  = 32'h0000_3000 + 32'($urandom_range(0, 15));
            rRs2   = $urandom;
            rRdata = $urandom;
            refModel(rLd, rSt, rAddr, rRs2, rRdata, mValM, mWdata, mWstrb, mMis);
            applyStimulus(rLd, rSt, rAddr, rRs2, rRdata, mValM, mWdata, mWstrb, mMis,
                          int'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
                          int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        // Reset while a load waits for its response, then a stray response after release.
        @(negedge clk_i);
        execute_vaild = 1'b1;
        ED_load_op    = 5'd4;
        ED_store_op   = 3'd0;
        ED_valE       = 32'h0000_4000;
        bus.gnt       = 1'b1;
        #1;
        checkOutput("rstmid req", 32'(bus.req), 32'h1);
        @(negedge clk_i);
        bus.gnt       = 1'b0;
        execute_vaild = 1'b0;
        rst           = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("rstmid vaild", 32'(memory_vaild), 32'h0);
        checkOutput("rstmid PC", MD_PC, 32'h0);
        checkOutput("rstmid valE", MD_valE, 32'h0);
        @(negedge clk_i);
        rst        = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBAD0_BAD0;
        #1;
        checkOutput("stray req", 32'(bus.req), 32'h0);
        @(posedge clk_i);
        #1;
        bus.rvalid = 1'b0;
        checkOutput("stray vaild", 32'(memory_vaild), 32'h0);
        checkOutput("stray valM", MD_valM, 32'h0);
        @(negedge clk_i);
        execute_vaild = 1'b1;
        #1;
        checkOutput("post-reset idle req", 32'(bus.req), 32'h1);
        checkOutput("post-reset allow_in", 32'(memory_allow_in), 32'h0);
        @(negedge clk_i);
        execute_vaild = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("post-reset vaild", 32'(memory_vaild), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory stage of the in-order pipeline. It consumes the execute/memory pipeline register outputs (ED_*) and performs data-memory loads and stores over a req/gnt/rvalid bus.
- Load data is byte/half-selected and sign- or zero-extended, then the result is captured into the memory/writeback pipeline register (MD_*).
- It drives memory_allow_in_o back to the execute/memory register, stalling it while a bus access is in flight or while writeback is blocked.

Parameters:
- XLEN, 32, data/address width.
- LOAD_WIDTH, 5, one-hot load op; bit0 LB, bit1 LH, bit2 LW, bit3 LBU, bit4 LHU.
- STORE_WIDTH, 3, one-hot store op; bit0 SB, bit1 SH, bit2 SW.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- execute_vaild_i  in  1  ED register holds a valid instruction.
- ED_load_op_i  in  LOAD_WIDTH  load op; 0 = no load.
- ED_store_op_i  in  STORE_WIDTH  store op; 0 = no store.
- ED_valE_i  in  XLEN  ALU result; this is the address for memory ops.
- ED_rs2_data_i  in  XLEN  store data.
- ED_need_dstE_i  in  1  writes a register.
- ED_dstE_i  in  5  destination register.
- ED_sel_reg_i  in  1  1 = writeback selects valM, 0 = valE.
- ED_PC_i  in  XLEN  instruction PC.
- ED_commit_i  in  1  commit flag.
- writeback_allow_in_i  in  1  writeback can accept this cycle.
- dmem_gnt_i  in  1  bus accepted the request this cycle.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  XLEN  load data.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  XLEN  word-aligned address ({ED_valE[31:2],2'b0}).
- dmem_wdata_o  out  XLEN  store data shifted into its byte lanes.
- dmem_wstrb_o  out  4  byte strobes.
- memory_allow_in_o  out  1  ED register may advance.
- memory_vaild_o  out  1  MD register holds a valid instruction.
- MD_valE_o  out  XLEN  captured ED_valE.
- MD_valM_o  out  XLEN  extended load result.
- MD_need_dstE_o  out  1  registered copy of ED_need_dstE.
- MD_dstE_o  out  5  registered copy of ED_dstE.
- MD_sel_reg_o  out  1  registered copy of ED_sel_reg.
- MD_PC_o  out  XLEN  registered copy of ED_PC.
- MD_commit_o  out  1  registered copy of ED_commit.
- MD_misalign_o  out  1  the instruction was a misaligned access.

Behaviour:
- Reset (rst=0):
  - state=IDLE; data buffer cleared.
  - All MD_* outputs, memory_vaild_o and MD_misalign_o are 0.
  - dmem_req_o is 0.
- memop = execute_vaild_i & (|load_op | |store_op).
- Misaligned access:
  - Definition: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - No bus request is issued; the instruction completes immediately with MD_misalign_o=1 and MD_need_dstE_o=0.
- States:
  - IDLE: dmem_req_o = memop & ~misaligned.
    - Load and gnt → WAIT.
    - Store and gnt: done; if writeback_allow_in_i=0 → HOLD.
    - No gnt: remain IDLE with req held; ED inputs are stable because allow_in=0.
  - WAIT: req=0.
    - rvalid and writeback_allow_in_i → capture, go to IDLE.
    - rvalid and ~writeback_allow_in_i → buffer the extended data, go to HOLD.
    - rvalid in IDLE is ignored, including a stale response after reset.
  - HOLD: access finished; when writeback_allow_in_i=1, capture (using the buffered valM for loads) and go to IDLE.
- done is 1 in any of these cases:
  - ~execute_vaild_i;
  - non-memop;
  - misaligned;
  - IDLE & store & gnt;
  - WAIT & rvalid;
  - HOLD.
- memory_allow_in_o = done & writeback_allow_in_i. This is combinational.
- MD register update:
  - When memory_allow_in_o=1, MD_* capture the ED inputs and valM, and memory_vaild_o ← execute_vaild_i.
  - If execute_vaild_i=0, the MD fields are cleared as a bubble.
  - Otherwise MD holds.
- Load extension (off = addr[1:0]):
  - LB/LBU take byte off, sign/zero-extended.
  - LH/LHU take half addr[1], sign/zero-extended.
  - LW takes the full word.
- Store encoding:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 1<<off.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = rs2, wstrb = 1111.
- Latency:
  - Non-memop: 0 extra cycles; captured in the same cycle it is presented.
  - Store: captured in the gnt cycle.
  - Load: captured in the rvalid cycle, at least 1 cycle after gnt.
- Reset mid-access: state returns to IDLE and the buffer is dropped. The bench must not drive rvalid for a discarded request after reset.
- Only one outstanding request at a time. No req is issued in WAIT or HOLD.

Test Plan:
- ADD, writeback_allow_in=1, valE=0x1234 → same-cycle allow_in=1; next cycle MD_valE=0x1234, memory_vaild=1, dmem_req=0.
- LB addr=0x1003, gnt in cycle 0, rvalid in cycle 2 with rdata=0x80FF_0000 → allow_in=0 in cycles 0–1, allow_in=1 in cycle 2; MD_valM=0xFFFFFF80. Same data with LBU → 0x00000080.
- SH addr=0x2002, rs2=0xABCD, gnt immediate → wstrb=1100, wdata=0xABCDABCD, addr=0x2000, we=1, captured in the same cycle.
- LW whose rvalid (rdata=0xDEADBEEF) arrives while writeback_allow_in=0 for 3 cycles → FSM in HOLD, MD unchanged, allow_in=0; when writeback_allow_in rises, MD_valM=0xDEADBEEF.
- LW addr=0x1002 → no req; MD_misalign=1, MD_need_dstE=0, captured in the same cycle.
- Reset asserted in WAIT, then a stray rvalid after release → all outputs 0, state IDLE, stray rvalid ignored, memory_vaild=0.
